// File: rtl/uart_frame_pkg.sv
// Shared constants for the 18-byte UART command protocol of the ECP5 coprocessor:
// frame geometry, command characters and the master FSM encoding.
package uart_frame_pkg;

    localparam int FRAME_BYTES  = 18;
    localparam int PAYLOAD_BITS = 128;
    localparam int FRAME_BITS   = FRAME_BYTES * 8;

    localparam logic [7:0] OP_TEST     = 8'h41; // "A"
    localparam logic [7:0] OP_READ_CT  = 8'h40; // "@"
    localparam logic [7:0] OP_READ_KEY = 8'h61; // "a"
    localparam logic [7:0] OP_READ_PT  = 8'h62; // "b"
    localparam logic [7:0] OP_WR_KEY   = 8'h43; // "C"
    localparam logic [7:0] OP_WR_PT    = 8'h44; // "D"
    localparam logic [7:0] OP_ENC      = 8'h45; // "E"

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEND     = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;
    localparam logic [1:0] ST_FINISH   = 2'd3;

    // The opcode is repeated as the trailing byte so the coprocessor can detect framing slips.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [7:0]              op,
        input logic [PAYLOAD_BITS-1:0] payload
    );
        return {op, payload, op};
    endfunction

endpackage

// File: rtl/uart_frame_master.sv
// Host-side initiator: serialises one {op, payload, op} frame per request over a byte UART
// and optionally collects the 18-byte reply, flagging an inter-byte timeout.
module uart_frame_master #(
    parameter int FRAME_BYTES    = uart_frame_pkg::FRAME_BYTES,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [7:0]                             cmd_op,
    input  logic [uart_frame_pkg::PAYLOAD_BITS-1:0] cmd_payload,
    input  logic                                   cmd_expect_rsp,
    output logic [7:0]                             tx_data,
    output logic                                   tx_valid,
    input  logic                                   tx_ready,
    input  logic [7:0]                             rx_data,
    input  logic                                   rx_valid,
    output logic                                   done,
    output logic                                   timeout,
    output logic [FRAME_BYTES*8-1:0]               rsp_data,
    output logic                                   busy
);
    import uart_frame_pkg::*;

    localparam int FRAME_W = FRAME_BYTES * 8;
    localparam int IDX_W   = $clog2(FRAME_BYTES);
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]         state_q,   state_d;
    logic [FRAME_W-1:0] frame_q,   frame_d;
    logic [IDX_W-1:0]   tx_idx_q,  tx_idx_d;
    logic               expect_q,  expect_d;
    logic [FRAME_W-1:0] rsp_q,     rsp_d;
    logic [IDX_W-1:0]   rx_idx_q,  rx_idx_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        tx_idx_d  = tx_idx_q;
        expect_d  = expect_q;
        rsp_d     = rsp_q;
        rx_idx_d  = rx_idx_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    frame_d   = build_frame(cmd_op, cmd_payload);
                    expect_d  = cmd_expect_rsp;
                    tx_idx_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = ST_SEND;
                end
            end

            ST_SEND: begin
                if (tx_ready) begin
                    frame_d  = {frame_q[FRAME_W-9:0], 8'h00};
                    tx_idx_d = tx_idx_q + IDX_W'(1);
                    if (tx_idx_q == LAST_IDX) begin
                        if (expect_q) begin
                            rsp_d    = '0;
                            rx_idx_d = '0;
                            cnt_d    = CNT_LOAD;
                            state_d  = ST_WAIT_RSP;
                        end else begin
                            state_d  = ST_FINISH;
                        end
                    end
                end
            end

            ST_WAIT_RSP: begin
                // A byte landing in the counter-zero cycle still counts; it takes priority.
                if (rx_valid) begin
                    for (int b = 0; b < FRAME_BYTES; b++) begin
                        if (rx_idx_q == IDX_W'(b)) begin
                            rsp_d[FRAME_W-1-8*b -: 8] = rx_data;
                        end
                    end
                    rx_idx_d = rx_idx_q + IDX_W'(1);
                    cnt_d    = CNT_LOAD;
                    if (rx_idx_q == LAST_IDX) begin
                        timeout_d = 1'b0;
                        state_d   = ST_FINISH;
                    end
                end else if (cnt_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            tx_idx_q  <= '0;
            expect_q  <= 1'b0;
            rsp_q     <= '0;
            rx_idx_q  <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            tx_idx_q  <= tx_idx_d;
            expect_q  <= expect_d;
            rsp_q     <= rsp_d;
            rx_idx_q  <= rx_idx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // All handshake outputs decode the state register only, so nothing is combinational from inputs.
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign tx_valid  = (state_q == ST_SEND);
    assign tx_data   = (state_q == ST_SEND) ? frame_q[FRAME_W-1 -: 8] : 8'h00;
    assign done      = (state_q == ST_FINISH);
    assign timeout   = timeout_q;
    assign rsp_data  = rsp_q;

endmodule
